// File: rtl/fetch_queue.sv
// Instruction fetch stage with a small prefetch FIFO.
// Owns the PC and fetches one word per cycle while there is room. It presents the queued
// {instruction, PC+4} head entry to decode. A redirect flushes the queue and reloads the PC.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'd0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic [31:0]               imem_addr_o,
  input  logic [31:0]               imem_instr_i,
  input  logic                      imem_valid_i,
  input  logic                      redirect_i,
  input  logic [31:0]               redirect_pc_i,
  input  logic                      stall_i,
  output logic [31:0]               instr_o,
  output logic [31:0]               pc4_o,
  output logic                      valid_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     pc4_q   [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     pc_q;

  logic        full;
  logic        pop;
  logic        push;
  logic [31:0] pc_plus4;

  // Target word alignment drops the low address bits of the redirect target.
  logic unused_rpc_lsb;
  assign unused_rpc_lsb = ^redirect_pc_i[1:0];

  // Handshake decode; a push into a full queue is only allowed when the head leaves.
  always_comb begin
    full     = (count_q == CntW'(DEPTH));
    valid_o  = (count_q != '0);
    pop      = valid_o & ~stall_i;
    push     = imem_valid_i & ~redirect_i & (~full | pop);
    pc_plus4 = pc_q + 32'd4;
  end

  // Control state: PC, pointers and occupancy; reset beats redirect beats push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= {PC_RESET[31:2], 2'b00};
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (redirect_i) begin
      pc_q     <= {redirect_pc_i[31:2], 2'b00};
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        pc_q     <= pc_plus4;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage; stale entries are harmless since pointers/count gate visibility.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wr_ptr_q] <= imem_instr_i;
      pc4_q[wr_ptr_q]   <= pc_plus4;
    end
  end

  // Head presentation straight from storage; zeros when empty.
  always_comb begin
    imem_addr_o = pc_q;
    count_o     = count_q;
    instr_o     = valid_o ? instr_q[rd_ptr_q] : 32'd0;
    pc4_o       = valid_o ? pc4_q[rd_ptr_q]   : 32'd0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, a drain-order sequence and a random run
// against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] PC_RESET = 32'd0;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        valid;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .PC_RESET(PC_RESET)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_addr_o  (imem_addr),
    .imem_instr_i (imem_instr),
    .imem_valid_i (imem_valid),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .stall_i      (stall),
    .instr_o      (instr),
    .pc4_o        (pc4),
    .valid_o      (valid),
    .count_o      (count)
  );

  // Combinational instruction memory: data is a fixed function of the address.
  assign imem_instr = 32'h2000_0000 + imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic        rd;
    logic [31:0] rpc;
    logic        st;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [2:0]  ec;
    logic [31:0] ea;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic iv, input logic rd, input logic [31:0] rpc,
                              input logic st, input logic ev, input logic [31:0] ei,
                              input logic [31:0] ep, input logic [2:0] ec, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.iv = iv; v.rd = rd; v.rpc = rpc; v.st = st;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.ea = ea;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] ei,
                           input logic [31:0] ep, input logic [2:0] ec, input logic [31:0] ea);
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
    check({tag, ".instr"}, instr, ei);
    check({tag, ".pc4"},   pc4, ep);
    check({tag, ".count"}, {29'd0, count}, {29'd0, ec});
    check({tag, ".addr"},  imem_addr, ea);
  endtask

  task automatic drive(input logic r, input logic iv, input logic rd, input logic [31:0] rpc,
                       input logic st);
    rst = r; imem_valid = iv; redirect = rd; redirect_pc = rpc; stall = st;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue of {instr, pc+4} plus the fetch PC.
  logic [63:0] mq[$];
  logic [31:0] mpc;

  task automatic model_edge(input logic r, input logic iv, input logic rd, input logic [31:0] rpc,
                            input logic st);
    bit p, ps;
    int sz;
    if (r) begin
      mq.delete();
      mpc = PC_RESET;
    end else if (rd) begin
      mq.delete();
      mpc = rpc & 32'hFFFF_FFFC;
    end else begin
      sz = mq.size();
      p  = (sz != 0) && !st;
      ps = iv && ((sz < DEPTH) || p);
      if (p) void'(mq.pop_front());
      if (ps) begin
        mq.push_back({32'h2000_0000 + mpc, mpc + 32'd4});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  initial begin
    logic [31:0] rpc;
    logic r, iv, rd, st, ev;
    logic [31:0] ei, ep;

    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    //              rst   iv    rd    rpc           st    ev    instr          pc4           cnt   addr
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         32'h0,        3'd0, 32'h0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2000_0000, 32'h4,        3'd1, 32'h4);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2000_0004, 32'h8,        3'd1, 32'h8);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2000_0004, 32'h8,        3'd2, 32'hC);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2000_0004, 32'h8,        3'd3, 32'h10);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2000_0004, 32'h8,        3'd4, 32'h14);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2000_0004, 32'h8,        3'd4, 32'h14);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2000_0004, 32'h8,        3'd4, 32'h14);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2000_0008, 32'hC,        3'd4, 32'h18);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2000_000C, 32'h10,       3'd4, 32'h1C);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 32'h103,      1'b1, 1'b0, 32'h0,         32'h0,        3'd0, 32'h100);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2000_0100, 32'h104,      3'd1, 32'h104);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         32'h0,        3'd0, 32'h104);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         32'h0,        3'd0, 32'h104);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,         32'h0,        3'd0, 32'h104);
    vecs[15] = mk(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,        32'h0,        3'd0, 32'hFFFF_FFFC);
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1FFF_FFFC, 32'h0,        3'd1, 32'h0);
    vecs[17] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1FFF_FFFC, 32'h0,        3'd2, 32'h4);
    vecs[18] = mk(1'b1, 1'b1, 1'b1, 32'h200,      1'b0, 1'b0, 32'h0,         32'h0,        3'd0, 32'h0);
    vecs[19] = mk(1'b0, 1'b1, 1'b1, 32'h40,       1'b0, 1'b0, 32'h0,         32'h0,        3'd0, 32'h40);
    vecs[20] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2000_0040, 32'h44,       3'd1, 32'h44);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].rd, vecs[i].rpc, vecs[i].st);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep, vecs[i].ec, vecs[i].ea);
    end

    // Fill under stall, then drain with memory idle: order must be 0, 4, 8, C.
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 6; i++) step();
    check("fill.count", {29'd0, count}, 32'd4);
    check("fill.addr", imem_addr, 32'h10);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d.instr", i), instr, 32'h2000_0000 + 32'(4 * i));
      check($sformatf("drain%0d.pc4", i), pc4, 32'(4 * i + 4));
      step();
    end
    check("drain.valid", {31'd0, valid}, 32'd0);
    check("drain.count", {29'd0, count}, 32'd0);
    check("drain.addr", imem_addr, 32'h10);

    // Randomised run against the reference model.
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    model_edge(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    step();
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 63) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      st  = ($urandom_range(0, 2) == 0);
      rpc = ($urandom_range(0, 1) == 0) ? $urandom : (32'hFFFF_FFF0 + $urandom_range(0, 15));
      drive(r, iv, rd, rpc, st);
      model_edge(r, iv, rd, rpc, st);
      step();
      ev = (mq.size() != 0);
      ei = ev ? mq[0][63:32] : 32'd0;
      ep = ev ? mq[0][31:0] : 32'd0;
      check_all($sformatf("rnd%0d", c), ev, ei, ep, 3'(mq.size()), mpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
